// File: rtl/dipsw_debounce_pkg.sv
// Shared constants and helpers for the DE1-SoC slide-switch debouncer.
package dipsw_debounce_pkg;

    localparam int DEF_WIDTH        = 10;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 10;

    // Width of a counter that must hold values 0..stableTicks; never narrower than one bit.
    function automatic int cntWidth(input int stableTicks);
        return (stableTicks < 1) ? 1 : $clog2(stableTicks + 1);
    endfunction

endpackage

// File: rtl/dipsw_debounce_cell.sv
// One debounced switch bit: follows its synchronised input only after
// STABLE_TICKS consecutive sample ticks of disagreement.
module debounce_cell
    import dipsw_debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic change
);

    localparam int CW = cntWidth(STABLE_TICKS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          dout_q;
    logic          dout_d;
    logic          change_q;
    logic          change_d;

    // Any return to agreement aborts a pending change; otherwise count ticks until the last one commits.
    always_comb begin
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        change_d = 1'b0;
        if (din == dout_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                dout_d   = din;
                cnt_d    = '0;
                change_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state; reset returns to the idle value without producing a strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            dout_q   <= RESET_VAL;
            change_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            change_q <= change_d;
        end
    end

    assign dout   = dout_q;
    assign change = change_q;

endmodule

// File: rtl/dipsw_debounce.sv
// Synchroniser, shared sample-tick prescaler and per-bit debounce cells for
// the slide switches feeding the DIP-switch PIO.
module dipsw_debounce
    import dipsw_debounce_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               TICK_DIV     = DEF_TICK_DIV,
    parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] change_pulse,
    output logic             any_change
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [PW-1:0]    prescaler_q;
    logic [PW-1:0]    prescaler_d;
    logic             tick;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Free-running prescaler wrapping at TICK_DIV-1; input activity never restarts it.
    always_comb begin
        tick        = (prescaler_q == PW'(TICK_DIV - 1));
        prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS),
            .RESET_VAL   (RESET_VAL[i])
        ) u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .tick   (tick),
            .din    (sync2_q[i]),
            .dout   (debounced_out[i]),
            .change (change_pulse[i])
        );
    end

    // The per-bit strobes are already flops, so their OR carries the same timing.
    assign any_change = |change_pulse;

endmodule

// File: tb/tb_dipsw_debounce.sv
// Directed bench for dipsw_debounce with a short tick so whole debounce sequences fit in a few cycles.
module tb_dipsw_debounce;

    localparam int W  = 10;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int LAT_MIN = 2 + (ST - 1) * TD + 1;
    localparam int LAT_MAX = 2 + ST * TD;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] debounced_out;
    logic [W-1:0] change_pulse;
    logic         any_change;

    int total = 0;
    int bad   = 0;

    int           pulseCount [W];
    int           riseCount  [W];
    int           anyCount;
    logic [W-1:0] prevOut;

    dipsw_debounce #(
        .WIDTH       (W),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST),
        .RESET_VAL   ('0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_in       (raw_in),
        .debounced_out(debounced_out),
        .change_pulse (change_pulse),
        .any_change   (any_change)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally strobes and rising output edges on the inactive edge.
    initial begin
        anyCount = 0;
        prevOut  = '0;
        for (int i = 0; i < W; i++) begin
            pulseCount[i] = 0;
            riseCount[i]  = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < W; k++) begin
            if (change_pulse[k] === 1'b1) pulseCount[k] = pulseCount[k] + 1;
            if (debounced_out[k] === 1'b1 && prevOut[k] !== 1'b1) riseCount[k] = riseCount[k] + 1;
        end
        if (any_change === 1'b1) anyCount = anyCount + 1;
        prevOut = debounced_out;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
        total++;
        assert (observed >= lo && observed <= hi)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Steps until debounced_out[idx] shows val; cycles stays -1 if the bound expires.
    task automatic waitForBit(input int idx, input logic val, output int cycles);
        cycles = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (debounced_out[idx] === val) begin
                cycles = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int p0, p3, p5, p7, r5, r7, a0;

        $display("[TB] starting dipsw_debounce directed test");
        reset_n = 1'b0;
        raw_in  = '1;

        // Reset with all switches up; outputs stay at the reset value.
        applyStimulus(4);
        checkOutput("rst_out", 32'(debounced_out), 32'h0);
        checkOutput("rst_pulse", 32'(change_pulse), 32'h0);
        checkOutput("rst_any", 32'(any_change), 32'h0);
        a0 = anyCount;
        reset_n = 1'b1;
        waitForBit(0, 1'b1, lat);
        checkRange("rel_latency", lat, LAT_MIN, LAT_MAX);
        checkOutput("rel_out", 32'(debounced_out), 32'h3FF);
        checkOutput("rel_pulse", 32'(change_pulse), 32'h3FF);
        applyStimulus(20);
        checkOutput("rel_any_once", 32'(anyCount - a0), 32'd1);

        // Re-reset with all switches down.
        reset_n = 1'b0;
        raw_in  = '0;
        applyStimulus(3);
        reset_n = 1'b1;
        applyStimulus(10);
        checkOutput("idle_out", 32'(debounced_out), 32'h0);

        // Single clean rising edge on bit 3.
        p3 = pulseCount[3];
        raw_in[3] = 1'b1;
        waitForBit(3, 1'b1, lat);
        checkRange("b3_latency", lat, LAT_MIN, LAT_MAX);
        checkOutput("b3_pulse_first", 32'(change_pulse), 32'h008);
        checkOutput("b3_any_first", 32'(any_change), 32'h1);
        checkOutput("b3_out", 32'(debounced_out), 32'h008);
        applyStimulus(1);
        checkOutput("b3_pulse_after", 32'(change_pulse), 32'h0);
        checkOutput("b3_out_held", 32'(debounced_out), 32'h008);
        applyStimulus(20);
        checkOutput("b3_pulse_once", 32'(pulseCount[3] - p3), 32'd1);

        // Seven-cycle glitch on bit 0 must be rejected.
        p0 = pulseCount[0];
        a0 = anyCount;
        raw_in[0] = 1'b1;
        applyStimulus(7);
        raw_in[0] = 1'b0;
        applyStimulus(30);
        checkOutput("glitch_out", 32'(debounced_out), 32'h008);
        checkOutput("glitch_pulse", 32'(pulseCount[0] - p0), 32'd0);
        checkOutput("glitch_any", 32'(anyCount - a0), 32'd0);

        // Bit 5 bounces 1,0,1,0 at 3-cycle spacing, then settles high.
        p5 = pulseCount[5];
        r5 = riseCount[5];
        raw_in[5] = 1'b1; applyStimulus(3);
        raw_in[5] = 1'b0; applyStimulus(3);
        raw_in[5] = 1'b1; applyStimulus(3);
        raw_in[5] = 1'b0; applyStimulus(3);
        raw_in[5] = 1'b1;
        waitForBit(5, 1'b1, lat);
        checkRange("bounce_latency", lat, LAT_MIN, LAT_MAX);
        applyStimulus(20);
        checkOutput("bounce_rises", 32'(riseCount[5] - r5), 32'd1);
        checkOutput("bounce_pulses", 32'(pulseCount[5] - p5), 32'd1);
        checkOutput("bounce_out", 32'(debounced_out), 32'h028);

        // Bits 2 and 9 rise together and update in the same cycle.
        a0 = anyCount;
        raw_in[2] = 1'b1;
        raw_in[9] = 1'b1;
        waitForBit(2, 1'b1, lat);
        checkRange("pair_latency", lat, LAT_MIN, LAT_MAX);
        checkOutput("pair_bit9", 32'(debounced_out[9]), 32'h1);
        checkOutput("pair_pulse", 32'(change_pulse), 32'h204);
        checkOutput("pair_any", 32'(any_change), 32'h1);
        applyStimulus(1);
        checkOutput("pair_pulse_after", 32'(change_pulse), 32'h0);
        checkOutput("pair_any_after", 32'(any_change), 32'h0);
        applyStimulus(20);
        checkOutput("pair_any_once", 32'(anyCount - a0), 32'd1);
        checkOutput("pair_out", 32'(debounced_out), 32'h22C);

        // Bit 7 rises, reset hits after two ticks of disagreement, debounce restarts on release.
        p7 = pulseCount[7];
        r7 = riseCount[7];
        raw_in[7] = 1'b1;
        applyStimulus(9);
        checkOutput("mid_not_yet", 32'(debounced_out[7]), 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_out", 32'(debounced_out), 32'h0);
        applyStimulus(3);
        checkOutput("mid_rst_pulse", 32'(change_pulse), 32'h0);
        checkOutput("mid_rst_any", 32'(any_change), 32'h0);
        checkOutput("mid_rst_count", 32'(pulseCount[7] - p7), 32'd0);
        a0 = anyCount;
        reset_n = 1'b1;
        waitForBit(7, 1'b1, lat);
        checkRange("mid_latency", lat, LAT_MIN, LAT_MAX);
        checkOutput("mid_pulse", 32'(change_pulse), 32'h2AC);
        applyStimulus(20);
        checkOutput("mid_pulse_once", 32'(pulseCount[7] - p7), 32'd1);
        checkOutput("mid_rise_once", 32'(riseCount[7] - r7), 32'd1);
        checkOutput("mid_any_once", 32'(anyCount - a0), 32'd1);
        checkOutput("mid_out", 32'(debounced_out), 32'h2AC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
